// File: rtl/game_pkg.sv
// Shared constants for the four-fighter arena: character indices, round-state
// encodings and default HP sizing.
package game_pkg;

   localparam int CHAR_MAGE     = 0;
   localparam int CHAR_GUNMAN   = 1;
   localparam int CHAR_SWORDMAN = 2;
   localparam int CHAR_FISTMAN  = 3;
   localparam int NUM_CHAR      = 4;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_PLAY = 2'b01;
   localparam logic [1:0] ST_OVER = 2'b10;

   localparam int DEF_MAX_HP = 5;
   localparam int DEF_HP_W   = 3;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/hp_channel.sv
// One fighter's hit path: hit-level synchronizer, HP register with saturating
// damage, invulnerability down-counter, damage pulse and alive flag.
module hp_channel
   import game_pkg::*;
#(
   parameter int MAX_HP        = DEF_MAX_HP,
   parameter int HP_W          = DEF_HP_W,
   parameter int DAMAGE        = 1,
   parameter int INVULN_CYCLES = 6250000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            hit_in,
   input  logic            enable,
   input  logic            reload,
   output logic [HP_W-1:0] hp,
   output logic            alive,
   output logic            invuln,
   output logic            damage_pulse
);

   localparam int              CNT_W    = $clog2(INVULN_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_CYCLES);

   logic             hit_m;
   logic             hit_s;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic [HP_W-1:0]  hp_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_m <= 1'b0;
         hit_s <= 1'b0;
      end else begin
         hit_m <= hit_in;
         hit_s <= hit_m;
      end
   end

   assign accept = enable && hit_s && alive && (cnt == '0);

   // DAMAGE may not fit in HP_W, so compare at integer width and only subtract
   // when the result stays positive.
   always_comb begin
      hp_hit = '0;
      if (int'(hp) > DAMAGE)
         hp_hit = hp - HP_W'(DAMAGE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hp           <= HP_W'(MAX_HP);
         alive        <= 1'b1;
         cnt          <= '0;
         damage_pulse <= 1'b0;
      end else if (reload) begin
         hp           <= HP_W'(MAX_HP);
         alive        <= 1'b1;
         cnt          <= '0;
         damage_pulse <= 1'b0;
      end else begin
         damage_pulse <= accept;
         if (accept) begin
            hp <= hp_hit;
            if (hp_hit == '0) begin
               alive <= 1'b0;
               cnt   <= '0;
            end else begin
               cnt <= CNT_LOAD;
            end
         end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   assign invuln = (cnt != '0);

endmodule

// File: rtl/health_tracker.sv
// Round controller for the arena: four hp_channel instances plus the
// idle/play/over FSM and the survivor/winner encoder.
//
// state   | meaning
// IDLE    | waiting for start, hits ignored
// PLAY    | round running, hits damage fighters
// OVER    | at most one fighter left, results held until start
module health_tracker
   import game_pkg::*;
#(
   parameter int MAX_HP        = DEF_MAX_HP,
   parameter int HP_W          = DEF_HP_W,
   parameter int DAMAGE        = 1,
   parameter int INVULN_CYCLES = 6250000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [3:0]               hit_in,
   output logic [NUM_CHAR*HP_W-1:0] hp_out,
   output logic [3:0]               alive,
   output logic [3:0]               invuln,
   output logic [3:0]               damage_pulse,
   output logic [1:0]               state,
   output logic                     game_over,
   output logic [1:0]               winner,
   output logic                     winner_valid
);

   logic       enable;
   logic       reload;
   logic [2:0] n_alive;
   logic [1:0] survivor;

   assign enable = (state == ST_PLAY);
   assign reload = start && (state != ST_PLAY);

   for (genvar i = 0; i < NUM_CHAR; i++) begin : g_ch
      hp_channel #(
         .MAX_HP        (MAX_HP),
         .HP_W          (HP_W),
         .DAMAGE        (DAMAGE),
         .INVULN_CYCLES (INVULN_CYCLES)
      ) u_ch (
         .clk          (clk),
         .reset        (reset),
         .hit_in       (hit_in[i]),
         .enable       (enable),
         .reload       (reload),
         .hp           (hp_out[i*HP_W +: HP_W]),
         .alive        (alive[i]),
         .invuln       (invuln[i]),
         .damage_pulse (damage_pulse[i])
      );
   end

   assign n_alive = popcount4(alive);

   always_comb begin
      survivor = 2'd0;
      for (int i = NUM_CHAR - 1; i >= 0; i--)
         if (alive[i]) survivor = 2'(i);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         winner       <= 2'd0;
         winner_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) state <= ST_PLAY;
            end
            ST_PLAY: begin
               if (n_alive <= 3'd1) begin
                  state        <= ST_OVER;
                  winner       <= (n_alive == 3'd1) ? survivor : 2'd0;
                  winner_valid <= (n_alive == 3'd1);
               end
            end
            ST_OVER: begin
               if (start) begin
                  state        <= ST_PLAY;
                  winner_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker with MAX_HP=3, INVULN_CYCLES=4; a second
// instance with DAMAGE=5 exercises HP saturation.
module tb_health_tracker;

   localparam int HP_W = 3;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [3:0]  hit_in;
   logic [11:0] hp_out;
   logic [3:0]  alive, invuln, damage_pulse;
   logic [1:0]  state, winner;
   logic        game_over, winner_valid;

   logic        reset5, start5;
   logic [3:0]  hit5;
   logic [11:0] hp_out5;
   logic [3:0]  alive5, invuln5, damage_pulse5;
   logic [1:0]  state5, winner5;
   logic        game_over5, winner_valid5;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      string       tag;
      logic [29:0] exp;
      bit          sel;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   health_tracker #(.MAX_HP(3), .HP_W(HP_W), .DAMAGE(1), .INVULN_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .start(start), .hit_in(hit_in),
      .hp_out(hp_out), .alive(alive), .invuln(invuln), .damage_pulse(damage_pulse),
      .state(state), .game_over(game_over), .winner(winner), .winner_valid(winner_valid)
   );

   health_tracker #(.MAX_HP(3), .HP_W(HP_W), .DAMAGE(5), .INVULN_CYCLES(4)) dut5 (
      .clk(clk), .reset(reset5), .start(start5), .hit_in(hit5),
      .hp_out(hp_out5), .alive(alive5), .invuln(invuln5), .damage_pulse(damage_pulse5),
      .state(state5), .game_over(game_over5), .winner(winner5), .winner_valid(winner_valid5)
   );

   function automatic logic [29:0] mk(int h0, int h1, int h2, int h3,
                                      logic [3:0] al, logic [3:0] iv, logic [3:0] dp,
                                      logic [1:0] st, logic wv, logic [1:0] w);
      logic go;
      go = (st == 2'b10);
      return {3'(h3), 3'(h2), 3'(h1), 3'(h0), al, iv, dp, st, go, w, wv};
   endfunction

   function automatic logic [29:0] snap(bit sel);
      if (sel)
         return {hp_out5, alive5, invuln5, damage_pulse5, state5, game_over5, winner5, winner_valid5};
      return {hp_out, alive, invuln, damage_pulse, state, game_over, winner, winner_valid};
   endfunction

   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(string tag, logic [29:0] e, bit sel = 1'b0);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      x.sel = sel;
      sb.push_back(x);
   endtask

   task automatic check();
      exp_t e;
      logic [29:0] obs;
      e   = sb.pop_front();
      obs = snap(e.sel);
      n_vec++;
      assert (obs === e.exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
   endtask

   task automatic expect_after(string tag, logic [29:0] e, int n, bit sel = 1'b0);
      push(tag, e, sel);
      step(n);
      check();
   endtask

   localparam logic [1:0] I = 2'b00, P = 2'b01, O = 2'b10;

   initial begin
      reset = 1'b0; start = 1'b0; hit_in = 4'b0;
      reset5 = 1'b0; start5 = 1'b0; hit5 = 4'b0;
      expect_after("reset_state", mk(3,3,3,3, 4'hF,4'h0,4'h0, I,0,0), 2);

      // hits ignored in IDLE
      reset = 1'b1; reset5 = 1'b1;
      hit_in = 4'b0001;
      expect_after("idle_ignore", mk(3,3,3,3, 4'hF,4'h0,4'h0, I,0,0), 10);
      hit_in = 4'b0; step(3);

      start = 1'b1;
      expect_after("start_play", mk(3,3,3,3, 4'hF,4'h0,4'h0, P,0,0), 1);
      start = 1'b0;

      // single one-cycle hit on mage
      hit_in = 4'b0001; step(1); hit_in = 4'b0;
      expect_after("hit0_update", mk(2,3,3,3, 4'hF,4'b0001,4'b0001, P,0,0), 2);
      expect_after("hit0_pulse_end", mk(2,3,3,3, 4'hF,4'b0001,4'b0000, P,0,0), 1);
      expect_after("hit0_invuln_last", mk(2,3,3,3, 4'hF,4'b0001,4'b0000, P,0,0), 2);
      expect_after("hit0_invuln_off", mk(2,3,3,3, 4'hF,4'b0000,4'b0000, P,0,0), 1);

      // continuous hit on gunman: one accepted hit per 5 cycles
      hit_in = 4'b0010;
      expect_after("hold1_hp2", mk(2,2,3,3, 4'hF,4'b0010,4'b0010, P,0,0), 3);
      expect_after("hold1_hp1", mk(2,1,3,3, 4'hF,4'b0010,4'b0010, P,0,0), 5);
      expect_after("hold1_dead", mk(2,0,3,3, 4'b1101,4'b0000,4'b0010, P,0,0), 5);
      expect_after("hold1_stays0", mk(2,0,3,3, 4'b1101,4'b0000,4'b0000, P,0,0), 6);
      hit_in = 4'b0;

      // kill swordman, then fistman
      hit_in = 4'b0100;
      expect_after("kill2_hp2", mk(2,0,2,3, 4'b1101,4'b0100,4'b0100, P,0,0), 3);
      expect_after("kill2_hp1", mk(2,0,1,3, 4'b1101,4'b0100,4'b0100, P,0,0), 5);
      expect_after("kill2_dead", mk(2,0,0,3, 4'b1001,4'b0000,4'b0100, P,0,0), 5);
      hit_in = 4'b1000;
      expect_after("kill3_hp2", mk(2,0,0,2, 4'b1001,4'b1000,4'b1000, P,0,0), 3);
      expect_after("kill3_hp1", mk(2,0,0,1, 4'b1001,4'b1000,4'b1000, P,0,0), 5);
      expect_after("kill3_dead", mk(2,0,0,0, 4'b0001,4'b0000,4'b1000, P,0,0), 5);
      hit_in = 4'b0;
      expect_after("over_winner0", mk(2,0,0,0, 4'b0001,4'b0000,4'b0000, O,1,0), 1);
      hit_in = 4'b0001;
      expect_after("over_hold", mk(2,0,0,0, 4'b0001,4'b0000,4'b0000, O,1,0), 6);
      hit_in = 4'b0; step(3);
      start = 1'b1;
      expect_after("restart_play", mk(3,3,3,3, 4'hF,4'h0,4'h0, P,0,0), 1);
      start = 1'b0;

      // simultaneous final hits on mage and gunman
      hit_in = 4'b1111;
      expect_after("all_hp2", mk(2,2,2,2, 4'hF,4'hF,4'hF, P,0,0), 3);
      expect_after("all_hp1", mk(1,1,1,1, 4'hF,4'hF,4'hF, P,0,0), 5);
      hit_in = 4'b1100;
      expect_after("two_left", mk(1,1,0,0, 4'b0011,4'b0000,4'b1100, P,0,0), 5);
      hit_in = 4'b0011;
      expect_after("double_ko", mk(0,0,0,0, 4'b0000,4'b0000,4'b0011, P,0,0), 3);
      expect_after("over_no_winner", mk(0,0,0,0, 4'b0000,4'b0000,4'b0000, O,0,0), 1);
      hit_in = 4'b0; step(3);

      // asynchronous reset mid-round with swordman invulnerable at hp 1
      start = 1'b1;
      expect_after("restart2_play", mk(3,3,3,3, 4'hF,4'h0,4'h0, P,0,0), 1);
      start = 1'b0;
      hit_in = 4'b0100;
      expect_after("pre_rst_hp2", mk(3,3,2,3, 4'hF,4'b0100,4'b0100, P,0,0), 3);
      expect_after("pre_rst_hp1", mk(3,3,1,3, 4'hF,4'b0100,4'b0100, P,0,0), 5);
      hit_in = 4'b0;
      #2 reset = 1'b0;
      #1;
      push("async_reset", mk(3,3,3,3, 4'hF,4'h0,4'h0, I,0,0));
      check();
      step(1);
      reset = 1'b1;

      // DAMAGE=5 saturates at zero
      start5 = 1'b1; step(1); start5 = 1'b0;
      hit5 = 4'b0001; step(1); hit5 = 4'b0;
      expect_after("dmg5_sat0", mk(0,3,3,3, 4'b1110,4'b0000,4'b0001, P,0,0), 2, 1'b1);
      hit5 = 4'b1111;
      expect_after("dmg5_all", mk(0,0,0,0, 4'b0000,4'b0000,4'b1110, P,0,0), 3, 1'b1);
      expect_after("dmg5_over", mk(0,0,0,0, 4'b0000,4'b0000,4'b0000, O,0,0), 1, 1'b1);
      hit5 = 4'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
